mem_stream_reader: RTL and testbench

//  Sequential read engine placed directly downstream of a single-port block RAM (1-cycle read latency,

---
 rtl/mem_stream_pkg.sv | 31 +++
 rtl/stream_fifo2.sv | 69 ++++++
 rtl/mem_stream_reader.sv | 142 ++++++++++++++
 tb/tb_mem_stream_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_pkg.sv
// Shared definitions for the memory stream reader: FSM encodings, output FIFO
// sizing and the read-credit rule that keeps the FIFO from overflowing.
package mem_stream_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W      = FIFO_CNT_W + 1;

  // A read may issue only if every word already owed to the FIFO, minus the
  // one leaving this cycle, still leaves a free slot for the new one.
  function automatic logic credit_ok(input logic [FIFO_CNT_W-1:0] count,
                                     input logic                  in_flight,
                                     input logic                  pop);
    logic [OCC_W-1:0] occ;
    occ = {1'b0, count} + OCC_W'(in_flight) - OCC_W'(pop);
    return occ < OCC_W'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO; the head register drives the stream directly so the
// output word is stable for as long as it is not popped.
module stream_fifo2
  import mem_stream_pkg::*;
#(
  parameter int W = 9
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          wr_data,
  output logic [W-1:0]          rd_data,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  not_empty
);

  logic [W-1:0]          head_q, head_d;
  logic [W-1:0]          tail_q, tail_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == '0) head_d = wr_data;
        else               tail_d = wr_data;
        count_d = count_q + FIFO_CNT_W'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - FIFO_CNT_W'(1);
      end
      2'b11: begin
        if (count_q == FIFO_CNT_W'(1)) begin
          head_d = wr_data;
        end else begin
          head_d = tail_q;
          tail_d = wr_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: only two words of storage, so the data registers are reset too; this
  // gives a defined out_data after reset at negligible cost.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rd_data   = head_q;
  assign count     = count_q;
  assign not_empty = (count_q != '0);

endmodule

// File: rtl/mem_stream_reader.sv
// Sweeps a 1-cycle-latency block RAM from base_addr for length words and
// re-emits them as a valid/ready stream with last, tolerating back-pressure.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rd,
  input  logic [WIDTH-1:0]  mem_q,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH:0]          fifo_rd;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic                    fifo_valid;
  logic                    pop;
  logic [CNT_W-1:0]        last_idx;
  logic [ADDR_W-1:0]       addr_next;

  assign pop       = fifo_valid && out_ready;
  assign last_idx  = len_q - CNT_W'(1);
  assign addr_next = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

  // Issue decision is same-cycle so a pop frees a slot immediately, which is
  // what sustains one beat per cycle with only two FIFO entries.
  assign mem_rd      = (state_q == RUN) && credit_ok(fifo_count, rd_pend_q, pop);
  assign mem_address = mem_rd ? addr_q : mem_address_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    mem_address_d = mem_address_q;
    len_d         = len_q;
    issue_cnt_d   = issue_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    rd_pend_d     = mem_rd;
    rd_last_d     = mem_rd && (issue_cnt_q == last_idx);

    if (pop) beat_cnt_d = beat_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          len_d       = length;
          issue_cnt_d = '0;
          beat_cnt_d  = '0;
          state_d     = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (mem_rd) begin
          mem_address_d = addr_q;
          addr_d        = addr_next;
          issue_cnt_d   = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == last_idx) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (beat_cnt_q == last_idx)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      mem_address_q <= '0;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      beat_cnt_q    <= '0;
      rd_pend_q     <= 1'b0;
      rd_last_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      mem_address_q <= mem_address_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      rd_pend_q     <= rd_pend_d;
      rd_last_q     <= rd_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // RAM data lands in the FIFO the cycle after the read regardless of out_ready;
  // the credit check guarantees there is room.
  stream_fifo2 #(
    .W(WIDTH + 1)
  ) u_fifo (
    .clock    (clock),
    .rst_n    (rst_n),
    .push     (rd_pend_q),
    .pop      (pop),
    .wr_data  ({rd_last_q, mem_q}),
    .rd_data  (fifo_rd),
    .count    (fifo_count),
    .not_empty(fifo_valid)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = fifo_valid;
  assign out_data  = fifo_rd[WIDTH-1:0];
  assign out_last  = fifo_rd[WIDTH] && fifo_valid;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: stimulus queues expected beats and
// read addresses, a negedge monitor checks every read and every transfer.
module tb_mem_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic             clock;
  logic             rst_n;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      length;
  logic             busy;
  logic             done;
  logic [AW-1:0]    mem_address;
  logic             mem_rd;
  logic [WIDTH-1:0] mem_q;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  logic [WIDTH-1:0] ram [DEPTH];

  beat_t         exp_q [$];
  logic [AW-1:0] addr_q [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int beats, rds, issued, popped;
  int first_beat_cyc, last_beat_cyc;
  int done_cnt = 0;
  int done_base = 0;
  int done_cyc = 0;
  logic             stall_pending = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic             held_last;

  mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .mem_address(mem_address),
    .mem_rd     (mem_rd),
    .mem_q      (mem_q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial mem_q = '0;
  always @(posedge clock) if (mem_rd) mem_q <= ram[mem_address];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_pending) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, held_data);
        check("stall_last_held", out_last, held_last);
      end
      if (mem_rd) begin
        check("rd_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("rd_address", mem_address, addr_q.pop_front());
        check("rd_credit", ((issued + 1) - (popped + int'(out_valid && out_ready))) <= 2, 1);
        issued++;
        rds++;
      end
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_last", out_last, e.last);
        end
        popped++;
        beats++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
      stall_pending = out_valid && !out_ready;
      held_data     = out_data;
      held_last     = out_last;
    end
  end

  task automatic push_exp(input logic last, input int data, input int addr);
    beat_t b;
    b.last = last;
    b.data = WIDTH'(data);
    exp_q.push_back(b);
    addr_q.push_back(AW'(addr));
  endtask

  task automatic push_model(input int b, input int l);
    for (int i = 0; i < l; i++)
      push_exp(i == l - 1, int'(ram[(b + i) % DEPTH]), (b + i) % DEPTH);
  endtask

  // Drives start for one cycle; returns #1 into cycle 1 with t0 marking cycle 0.
  task automatic start_cmd(input int b, input int l);
    @(posedge clock); #1;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW + 1)'(l);
    t0        = cyc;
    beats = 0; rds = 0; issued = 0; popped = 0;
    first_beat_cyc = -1;
    last_beat_cyc  = -1;
    done_base = done_cnt;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == done_base && n < bound) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock); #1;
    check("done_seen", done_cnt != done_base, 1);
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < t0 + k) @(negedge clock);
  endtask

  logic [5:0] pat;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i);
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // 1: base 0, length 4, full throughput latency
    push_exp(0, 0, 0); push_exp(0, 1, 1); push_exp(0, 2, 2); push_exp(1, 3, 3);
    start_cmd(0, 4);
    check("t1_busy_c1", busy, 1);
    check("t1_mem_rd_c1", mem_rd, 1);
    check("t1_addr_c1", mem_address, 0);
    wait_done(20);
    check("t1_first_beat_cyc", first_beat_cyc - t0, 3);
    check("t1_last_beat_cyc", last_beat_cyc - t0, 6);
    check("t1_done_cyc", done_cyc - t0, 7);
    wait_cyc(8);
    check("t1_busy_c8", busy, 0);
    check("t1_beats", beats, 4);

    // 2: address wrap 62,63,0,1
    push_exp(0, 62, 62); push_exp(0, 63, 63); push_exp(0, 0, 0); push_exp(1, 1, 1);
    start_cmd(62, 4);
    wait_done(20);
    check("t2_beats", beats, 4);
    check("t2_held_addr", mem_address, 1);

    for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i) ^ 8'h5A;

    // 3: back-pressure pattern 1,0,0,1,0,1
    pat = 6'b101001;
    push_model(20, 4);
    start_cmd(20, 4);
    for (int i = 0; i < 18; i++) begin
      @(posedge clock); #1;
      out_ready = pat[i % 6];
    end
    out_ready = 1'b1;
    wait_done(40);
    check("t3_beats", beats, 4);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: zero length, then start while busy is ignored
    start_cmd(7, 0);
    check("t4_done_c1", done, 1);
    check("t4_busy_c1", busy, 1);
    check("t4_mem_rd_c1", mem_rd, 0);
    wait_cyc(2);
    check("t4_done_c2", done, 0);
    check("t4_busy_c2", busy, 0);
    check("t4_no_reads", rds, 0);
    check("t4_no_beats", beats, 0);
    push_model(30, 4);
    start_cmd(30, 4);
    wait_cyc(2);
    start = 1'b1; base_addr = AW'(50); length = 7'd2;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(30);
    repeat (4) @(posedge clock);
    #1;
    check("t4_ignored_beats", beats, 4);
    check("t4_ignored_reads", rds, 4);
    check("t4_single_done", done_cnt - done_base, 1);
    check("t4_idle_busy", busy, 0);

    // 5: full depth from base 10
    push_model(10, 64);
    start_cmd(10, 64);
    wait_done(100);
    check("t5_beats", beats, 64);
    check("t5_reads", rds, 64);
    check("t5_done_cyc", done_cyc - t0, 67);

    // 6: reset with two beats buffered, then a fresh run
    out_ready = 1'b0;
    push_model(5, 8);
    start_cmd(5, 8);
    wait_cyc(6);
    check("t6_buffered_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_mem_rd", mem_rd, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_last", out_last, 0);
    check("t6_rst_mem_address", mem_address, 0);
    check("t6_rst_out_data", out_data, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push_model(40, 3);
    start_cmd(40, 3);
    wait_done(20);
    check("t6_beats", beats, 3);
    check("t6_done_cyc", done_cyc - t0, 6);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
